// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM state type and divide-by-zero result for md_unit.
package md_pkg;

    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;
    localparam logic [3:0] MD_MSUB  = 4'd11;
    localparam logic [3:0] MD_MSUBU = 4'd12;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;

    // x/0 fills LO with this bit; HI naturally ends up holding the dividend
    localparam logic MD_DIVZ_QUO_BIT = 1'b1;

endpackage

// File: rtl/md_divider.sv
// md_divider: iterative restoring divider core, one quotient bit per cycle on
// unsigned magnitudes. done is high in the cycle whose edge retires the last bit.
module md_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             running;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

    // quo shifts dividend bits out the top while quotient bits enter at the bottom
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs};
    assign done      = running && (cnt == CW'(1));
    assign quotient  = quo;
    assign remainder = rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (start) begin
            quo     <= dividend;
            rem     <= '0;
            dvs     <= divisor;
            cnt     <= CW'(WIDTH);
            running <= 1'b1;
        end else if (running) begin
            if (diff[WIDTH]) begin
                rem <= rem_shift[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end else begin
                rem <= diff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO registers, iterative divider and flush.
// Multiply-accumulate ops 9-12 are enabled by defining MD_MAC_EN.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] out
);

    localparam int CW = $clog2(MUL_LAT + 1);

    md_state_t          state;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      mcnt;
    logic               is_mac;
    logic               mac_sub;
    logic               neg_q;
    logic               neg_r;
    logic               divz;

    logic               mul_signed;
    logic               div_signed;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod_next;
    logic [2*WIDTH-1:0] commit_val;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               div_go;
    logic               div_done;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;

    assign mul_signed = (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
    assign div_signed = (op == MD_DIV);
    assign a_ext      = {{WIDTH{mul_signed & A[WIDTH-1]}}, A};
    assign b_ext      = {{WIDTH{mul_signed & B[WIDTH-1]}}, B};
    assign prod_next  = a_ext * b_ext;
    assign a_abs      = (div_signed && A[WIDTH-1]) ? -A : A;
    assign b_abs      = (div_signed && B[WIDTH-1]) ? -B : B;
    assign div_go     = (state == IDLE) && start && !flush && ((op == MD_DIV) || (op == MD_DIVU));

    assign commit_val = !is_mac ? prod :
                        mac_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);

    assign out = (op == MD_MFHI) ? hi : (op == MD_MFLO) ? lo : '0;

    md_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_go),
        .abort     (flush),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // HI/LO only change on commit or mthi/mtlo, so out shows old values while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            prod    <= '0;
            mcnt    <= '0;
            is_mac  <= 1'b0;
            mac_sub <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            divz    <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                prod    <= prod_next;
                                mcnt    <= CW'(MUL_LAT);
                                is_mac  <= 1'b0;
                                mac_sub <= 1'b0;
                                state   <= MUL;
                                busy    <= 1'b1;
                            end
`ifdef MD_MAC_EN
                            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
                                prod    <= prod_next;
                                mcnt    <= CW'(MUL_LAT);
                                is_mac  <= 1'b1;
                                mac_sub <= (op == MD_MSUB) || (op == MD_MSUBU);
                                state   <= MUL;
                                busy    <= 1'b1;
                            end
`else
                            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: ;
`endif
                            MD_DIV, MD_DIVU: begin
                                neg_q <= div_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                                neg_r <= div_signed && A[WIDTH-1];
                                divz  <= (B == '0);
                                state <= DIV;
                                busy  <= 1'b1;
                            end
                            MD_MTHI: hi <= A;
                            MD_MTLO: lo <= A;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (mcnt == CW'(1)) begin
                        {hi, lo} <= commit_val;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        mcnt <= mcnt - CW'(1);
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo    <= divz ? {WIDTH{MD_DIVZ_QUO_BIT}} : (neg_q ? -div_quo : div_quo);
                    hi    <= neg_r ? -div_rem : div_rem;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (WIDTH=32, MUL_LAT=5).
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        busy;
    logic [31:0] out;

    int total;
    int bad;

    md_unit #(.WIDTH(32), .MUL_LAT(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .flush (flush),
        .busy  (busy),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // One-cycle start pulse; returns at the negedge after the accepting edge
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        op    = 4'd0;
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        op = 4'd5;
        #1 h = out;
        op = 4'd6;
        #1 l = out;
        op = 4'd0;
    endtask

    // Counts negedges with busy high; bounded so a stuck unit cannot hang the run
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] h, l;
        read_hilo(h, l);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        total++; if (h !== 32'h0) begin bad++; $display("[TB] FAIL reset_hi: got %h expected 00000000", h); end
        total++; if (l !== 32'h0) begin bad++; $display("[TB] FAIL reset_lo: got %h expected 00000000", l); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_move();
        logic [31:0] h, l;
        issue(4'd7, 32'h1234, 32'h0);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mthi_busy: got %b expected 0", busy); end
        read_hilo(h, l);
        total++; if (l !== 32'h0) begin bad++; $display("[TB] FAIL mflo_after_mthi: got %h expected 00000000", l); end
        total++; if (h !== 32'h1234) begin bad++; $display("[TB] FAIL mfhi_after_mthi: got %h expected 00001234", h); end
        issue(4'd8, 32'h55, 32'h0);
        read_hilo(h, l);
        total++; if (l !== 32'h55) begin bad++; $display("[TB] FAIL mtlo: got %h expected 00000055", l); end
    endtask

    task automatic test_mult();
        logic [31:0] h, l;
        int n;
        issue(4'd1, 32'hFFFFFFFE, 32'd3);
        read_hilo(h, l);
        total++; if (l !== 32'h55) begin bad++; $display("[TB] FAIL mult_preop_lo: got %h expected 00000055", l); end
        wait_idle(n);
        total++; if (n !== 5) begin bad++; $display("[TB] FAIL mult_latency: got %0d expected 5", n); end
        read_hilo(h, l);
        total++; if (h !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", h); end
        total++; if (l !== 32'hFFFFFFFA) begin bad++; $display("[TB] FAIL mult_lo: got %h expected fffffffa", l); end
        issue(4'd2, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        read_hilo(h, l);
        total++; if (h !== 32'h2) begin bad++; $display("[TB] FAIL multu_hi: got %h expected 00000002", h); end
        total++; if (l !== 32'hFFFFFFFA) begin bad++; $display("[TB] FAIL multu_lo: got %h expected fffffffa", l); end
    endtask

    task automatic test_div();
        logic [31:0] h, l;
        int n;
        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        total++; if (n !== 33) begin bad++; $display("[TB] FAIL div_latency: got %0d expected 33", n); end
        read_hilo(h, l);
        total++; if (l !== 32'hFFFFFFFD) begin bad++; $display("[TB] FAIL div_lo: got %h expected fffffffd", l); end
        total++; if (h !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL div_hi: got %h expected ffffffff", h); end
        issue(4'd4, 32'h80000000, 32'h0);
        wait_idle(n);
        total++; if (n !== 33) begin bad++; $display("[TB] FAIL divu_zero_latency: got %0d expected 33", n); end
        read_hilo(h, l);
        total++; if (l !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL divu_zero_lo: got %h expected ffffffff", l); end
        total++; if (h !== 32'h80000000) begin bad++; $display("[TB] FAIL divu_zero_hi: got %h expected 80000000", h); end
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        read_hilo(h, l);
        total++; if (l !== 32'h80000000) begin bad++; $display("[TB] FAIL div_minneg1_lo: got %h expected 80000000", l); end
        total++; if (h !== 32'h0) begin bad++; $display("[TB] FAIL div_minneg1_hi: got %h expected 00000000", h); end
        issue(4'd3, 32'hFFFFFFFB, 32'h0);
        wait_idle(n);
        read_hilo(h, l);
        total++; if (l !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL div_zero_lo: got %h expected ffffffff", l); end
        total++; if (h !== 32'hFFFFFFFB) begin bad++; $display("[TB] FAIL div_zero_hi: got %h expected fffffffb", h); end
        issue(4'd4, 32'd100, 32'd7);
        wait_idle(n);
        read_hilo(h, l);
        total++; if (l !== 32'd14) begin bad++; $display("[TB] FAIL divu_lo: got %h expected 0000000e", l); end
        total++; if (h !== 32'd2) begin bad++; $display("[TB] FAIL divu_hi: got %h expected 00000002", h); end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] h, l;
        int n;
        issue(4'd1, 32'd2, 32'd3);
        start = 1'b1;
        op    = 4'd2;
        A     = 32'hFFFFFFFF;
        B     = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        op    = 4'd0;
        wait_idle(n);
        total++; if (n !== 4) begin bad++; $display("[TB] FAIL ignore_latency: got %0d expected 4", n); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ignore_no_restart: got %b expected 0", busy); end
        read_hilo(h, l);
        total++; if (h !== 32'h0) begin bad++; $display("[TB] FAIL ignore_hi: got %h expected 00000000", h); end
        total++; if (l !== 32'd6) begin bad++; $display("[TB] FAIL ignore_lo: got %h expected 00000006", l); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h, l;
        int n;
        @(negedge clk);
        start = 1'b1; op = 4'd8; A = 32'd7;
        @(negedge clk);
        op = 4'd7; A = 32'd9;
        @(negedge clk);
        op = 4'd1; A = 32'd4; B = 32'd5;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy); end
        read_hilo(h, l);
        total++; if (h !== 32'd9) begin bad++; $display("[TB] FAIL b2b_preop_hi: got %h expected 00000009", h); end
        total++; if (l !== 32'd7) begin bad++; $display("[TB] FAIL b2b_preop_lo: got %h expected 00000007", l); end
        wait_idle(n);
        start = 1'b1; op = 4'd8; A = 32'h77;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        read_hilo(h, l);
        total++; if (h !== 32'h0) begin bad++; $display("[TB] FAIL b2b_mult_hi: got %h expected 00000000", h); end
        total++; if (l !== 32'h77) begin bad++; $display("[TB] FAIL b2b_start_on_idle: got %h expected 00000077", l); end
    endtask

    task automatic test_flush();
        logic [31:0] h, l;
        issue(4'd7, 32'hAAAA, 32'h0);
        issue(4'd8, 32'hBBBB, 32'h0);
        issue(4'd4, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
        repeat (40) @(negedge clk);
        read_hilo(h, l);
        total++; if (h !== 32'hAAAA) begin bad++; $display("[TB] FAIL flush_hi: got %h expected 0000aaaa", h); end
        total++; if (l !== 32'hBBBB) begin bad++; $display("[TB] FAIL flush_lo: got %h expected 0000bbbb", l); end
        @(negedge clk);
        start = 1'b1; op = 4'd7; A = 32'h1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd0; flush = 1'b0;
        read_hilo(h, l);
        total++; if (h !== 32'hAAAA) begin bad++; $display("[TB] FAIL flush_discards_start: got %h expected 0000aaaa", h); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] h, l;
        issue(4'd1, 32'd3, 32'd3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_mid_busy: got %b expected 0", busy); end
        read_hilo(h, l);
        total++; if (h !== 32'h0) begin bad++; $display("[TB] FAIL reset_mid_hi: got %h expected 00000000", h); end
        total++; if (l !== 32'h0) begin bad++; $display("[TB] FAIL reset_mid_lo: got %h expected 00000000", l); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mac();
        logic [31:0] h, l;
        int n;
        issue(4'd8, 32'd5, 32'h0);
`ifdef MD_MAC_EN
        issue(4'd9, 32'd3, 32'd4);
        wait_idle(n);
        total++; if (n !== 5) begin bad++; $display("[TB] FAIL madd_latency: got %0d expected 5", n); end
        read_hilo(h, l);
        total++; if (l !== 32'd17) begin bad++; $display("[TB] FAIL madd_lo: got %h expected 00000011", l); end
        total++; if (h !== 32'h0) begin bad++; $display("[TB] FAIL madd_hi: got %h expected 00000000", h); end
        issue(4'd12, 32'd1, 32'd20);
        wait_idle(n);
        read_hilo(h, l);
        total++; if (h !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL msubu_hi: got %h expected ffffffff", h); end
        total++; if (l !== 32'hFFFFFFFD) begin bad++; $display("[TB] FAIL msubu_lo: got %h expected fffffffd", l); end
`else
        n = 0;
        issue(4'd9, 32'd3, 32'd4);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL nomac_busy: got %b expected 0", busy); end
        read_hilo(h, l);
        total++; if (l !== 32'd5) begin bad++; $display("[TB] FAIL nomac_lo: got %h expected 00000005", l); end
        issue(4'd12, 32'd1, 32'd20);
        read_hilo(h, l);
        total++; if (h !== 32'h0) begin bad++; $display("[TB] FAIL nomac_msubu_hi: got %h expected 00000000 (n=%0d)", h, n); end
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        A     = '0;
        B     = '0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] starting md_unit tests");
        test_reset();
        test_move();
        test_mult();
        test_div();
        test_busy_ignore();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_mac();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
